// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter sharing one spi_master among NUM_REQ requesters
// Grants, issues the PISO transfer, waits for SIPO completion (with watchdog) and returns the word.
module spi_master_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int MAX_XFER_SIZE    = 32,
  parameter int TIMEOUT_CYCLES   = 65535,
  localparam int XFER_CNT_WIDTH  = $clog2(MAX_XFER_SIZE)
) (
  input  logic                                i_sys_clk,
  input  logic                                i_sys_rst,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ*MAX_XFER_SIZE-1:0]    i_req_data,
  input  logic [NUM_REQ*XFER_CNT_WIDTH-1:0]   i_req_xfer_size,
  output logic [NUM_REQ-1:0]                  o_req_ack,
  output logic [NUM_REQ-1:0]                  o_rsp_vld,
  output logic [MAX_XFER_SIZE-1:0]            o_rsp_data,
  output logic                                o_rsp_err,
  output logic                                o_busy,
  output logic [MAX_XFER_SIZE-1:0]            o_piso_data,
  output logic [XFER_CNT_WIDTH-1:0]           o_piso_xfer_size,
  output logic                                o_piso_req,
  input  logic                                i_piso_ack,
  input  logic [MAX_XFER_SIZE-1:0]            i_sipo_data,
  input  logic                                i_sipo_rdy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]    WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PTR_W-1:0]   PTR_MAX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt;
  logic [PTR_W-1:0] pick;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_expired;
  int               idx;

  // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    pick = ptr;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[PTR_W'(idx)]) pick = PTR_W'(idx);
    end
  end

  // Expiry is judged on the edge that would bring the count to TIMEOUT_CYCLES.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      assign wd_expired = (wd_cnt >= WD_LAST);
    end else begin : g_no_wd
      assign wd_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state            <= IDLE;
      ptr              <= '0;
      gnt              <= '0;
      wd_cnt           <= '0;
      o_req_ack        <= '0;
      o_rsp_vld        <= '0;
      o_rsp_data       <= '0;
      o_rsp_err        <= 1'b0;
      o_busy           <= 1'b0;
      o_piso_data      <= '0;
      o_piso_xfer_size <= '0;
      o_piso_req       <= 1'b0;
    end else begin
      o_req_ack <= '0;
      o_rsp_vld <= '0;
      case (state)
        IDLE: begin
          if (|i_req) begin
            gnt              <= pick;
            ptr              <= (pick == PTR_MAX) ? '0 : pick + 1'b1;
            o_piso_data      <= i_req_data[int'(pick)*MAX_XFER_SIZE +: MAX_XFER_SIZE];
            o_piso_xfer_size <= i_req_xfer_size[int'(pick)*XFER_CNT_WIDTH +: XFER_CNT_WIDTH];
            o_req_ack        <= REQ_ONE << pick;
            o_piso_req       <= 1'b1;
            wd_cnt           <= '0;
            o_busy           <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_piso_ack) begin
            o_piso_req <= 1'b0;
            wd_cnt     <= wd_cnt + 1'b1;
            state      <= WAIT_DONE;
          end else if (wd_expired) begin
            o_piso_req <= 1'b0;
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
            o_rsp_vld  <= REQ_ONE << gnt;
            state      <= RESPOND;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (i_sipo_rdy) begin
            o_rsp_data <= i_sipo_data;
            o_rsp_err  <= 1'b0;
            o_rsp_vld  <= REQ_ONE << gnt;
            state      <= RESPOND;
          end else if (wd_expired) begin
            o_rsp_data <= '0;
            o_rsp_err  <= 1'b1;
            o_rsp_vld  <= REQ_ONE << gnt;
            state      <= RESPOND;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESPOND: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter
module tb_spi_master_arbiter;

  localparam int T = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] req_data = '0;
  logic [19:0]  req_size = '0;
  logic [3:0]   req_ack, rsp_vld;
  logic [31:0]  rsp_data, piso_data;
  logic         rsp_err, busy, piso_req;
  logic [4:0]   piso_size;
  logic         piso_ack = 1'b0;
  logic [31:0]  sipo_data = '0;
  logic         sipo_rdy = 1'b0;

  logic [2:0]   req3 = '0;
  logic [95:0]  data3 = '0;
  logic [14:0]  size3 = '0;
  logic [2:0]   ack3, vld3;
  logic [31:0]  rdata3, pdata3;
  logic         rerr3, busy3, preq3;
  logic [4:0]   psize3;
  logic         pack3 = 1'b0;
  logic         srdy3 = 1'b0;
  logic [31:0]  sdata3 = '0;

  int checks = 0;
  int errors = 0;
  int ptr_model = 0;

  typedef struct {
    int          gnt;
    int          lat;
    logic [31:0] pdata;
    logic [4:0]  psize;
    logic [3:0]  rvld;
    logic [31:0] rdata;
    logic        rerr;
    int          rcyc;
    int          pdrop;
    int          vwidth;
  } obs_t;

  spi_master_arbiter #(.NUM_REQ(4), .MAX_XFER_SIZE(32), .TIMEOUT_CYCLES(T)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_req(req), .i_req_data(req_data),
    .i_req_xfer_size(req_size), .o_req_ack(req_ack), .o_rsp_vld(rsp_vld),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_piso_data(piso_data), .o_piso_xfer_size(piso_size), .o_piso_req(piso_req),
    .i_piso_ack(piso_ack), .i_sipo_data(sipo_data), .i_sipo_rdy(sipo_rdy)
  );

  spi_master_arbiter #(.NUM_REQ(3), .MAX_XFER_SIZE(32), .TIMEOUT_CYCLES(0)) dut3 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_req(req3), .i_req_data(data3),
    .i_req_xfer_size(size3), .o_req_ack(ack3), .o_rsp_vld(vld3),
    .o_rsp_data(rdata3), .o_rsp_err(rerr3), .o_busy(busy3),
    .o_piso_data(pdata3), .o_piso_xfer_size(psize3), .o_piso_req(preq3),
    .i_piso_ack(pack3), .i_sipo_data(sdata3), .i_sipo_rdy(srdy3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  function automatic int rr_pick(input logic [7:0] m, input int p, input int n);
    for (int k = 0; k < n; k++)
      if (((m >> ((p + k) % n)) & 8'd1) != 0) return (p + k) % n;
    return -1;
  endfunction

  // Outcome of one transfer: ack on issue-relative cycle a, sipo_rdy pulse on cycle r.
  task automatic model_xfer(input int a, input int r, output int rcyc, output logic err, output int pdrop);
    if (a >= T) begin
      rcyc = T; err = 1'b1; pdrop = T;
    end else begin
      pdrop = a + 1;
      if (r > a && r <= T - 1) begin rcyc = r + 1; err = 1'b0; end
      else begin rcyc = T; err = 1'b1; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_model = 0;
  endtask

  // Drives one request and plays spi_master; cycle 0 is the first cycle o_piso_req is high.
  task automatic do_xfer(input logic [3:0] m, input int a, input int r, input logic [31:0] miso, output obs_t o);
    int n;
    o.gnt = -1; o.lat = -1; o.pdata = '0; o.psize = '0; o.rvld = '0;
    o.rdata = '0; o.rerr = 1'b0; o.rcyc = -1; o.pdrop = -1; o.vwidth = 0;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    req = m;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (req_ack != 4'd0) begin o.lat = c; break; end
    end
    if (o.lat < 0) begin req = '0; return; end
    for (int i = 0; i < 4; i++) if (((req_ack >> i) & 4'd1) != 0) o.gnt = i;
    o.pdata = piso_data;
    o.psize = piso_size;
    req = req & ~(4'd1 << o.gnt);
    for (int k = 0; k < 60; k++) begin
      if (o.pdrop < 0 && piso_req !== 1'b1) o.pdrop = k;
      if (rsp_vld != 4'd0) begin
        if (o.rcyc < 0) begin o.rcyc = k; o.rvld = rsp_vld; o.rdata = rsp_data; o.rerr = rsp_err; end
        o.vwidth++;
      end else if (o.rcyc >= 0) break;
      piso_ack  = (k == a);
      sipo_rdy  = (k == r);
      sipo_data = (k == r) ? miso : $urandom;
      @(negedge clk);
    end
    piso_ack = 1'b0;
    sipo_rdy = 1'b0;
    req = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({req_ack, rsp_vld, rsp_data, rsp_err, busy, piso_data, piso_size, piso_req} !== 80'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0", {req_ack, rsp_vld, rsp_data, rsp_err, busy, piso_data, piso_size, piso_req});
    end
  endtask

  task automatic test_single();
    obs_t o;
    req_data = {$urandom, $urandom, $urandom, 32'hA5A5_0F0F};
    req_size = {15'($urandom), 5'd16};
    do_xfer(4'b0001, 3, 6, 32'h1234_5678, o);
    ptr_model = 1;
    checks++; if (o.gnt !== 0) begin errors++; $display("FAIL single_grant: got %0d expected 0", o.gnt); end
    checks++; if (o.lat !== 1) begin errors++; $display("FAIL single_ack_latency: got %0d expected 1", o.lat); end
    checks++; if (o.pdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL single_piso_data: got %0h expected a5a50f0f", o.pdata); end
    checks++; if (o.psize !== 5'd16) begin errors++; $display("FAIL single_piso_size: got %0d expected 16", o.psize); end
    checks++; if (o.pdrop !== 4) begin errors++; $display("FAIL single_piso_req_drop: got %0d expected 4", o.pdrop); end
    checks++; if (o.rvld !== 4'b0001) begin errors++; $display("FAIL single_rsp_vld: got %b expected 0001", o.rvld); end
    checks++; if (o.rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_rsp_data: got %0h expected 12345678", o.rdata); end
    checks++; if (o.rerr !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %0b expected 0", o.rerr); end
    checks++; if (o.rcyc !== 7 || o.vwidth !== 1) begin errors++; $display("FAIL single_rsp_timing: got cyc %0d width %0d expected cyc 7 width 1", o.rcyc, o.vwidth); end
  endtask

  task automatic test_fairness();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    obs_t o;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      do_xfer(4'b1111, 1, 2, $urandom, o);
      checks++;
      if (o.gnt !== exp_seq[i]) begin errors++; $display("FAIL fairness[%0d]: got grant %0d expected %0d", i, o.gnt, exp_seq[i]); end
    end
    ptr_model = 1;
  endtask

  task automatic test_wrap();
    logic [3:0] masks [3] = '{4'b0100, 4'b0101, 4'b0100};
    int exp_g [3] = '{2, 0, 2};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_xfer(masks[i], 0, 1, $urandom, o);
      checks++;
      if (o.gnt !== exp_g[i]) begin errors++; $display("FAIL wrap[%0d]: got grant %0d expected %0d", i, o.gnt, exp_g[i]); end
    end
    ptr_model = 3;
  endtask

  task automatic test_timeout();
    obs_t o;
    int late_vld;
    do_xfer(4'b0010, 2, 1000, 32'hDEAD_BEEF, o);
    ptr_model = 2;
    checks++; if (o.rvld !== 4'b0010 || o.rerr !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp: got vld %b err %0b data %0h expected vld 0010 err 1 data 0", o.rvld, o.rerr, o.rdata); end
    checks++; if (o.rcyc !== T) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", o.rcyc, T); end
    late_vld = 0;
    sipo_rdy = 1'b1; sipo_data = 32'hCAFE_F00D;
    @(negedge clk);
    sipo_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_vld != 4'd0 || busy !== 1'b0) late_vld++;
      @(negedge clk);
    end
    checks++; if (late_vld !== 0) begin errors++; $display("FAIL late_sipo_rdy: got %0d active cycles expected 0", late_vld); end
    do_xfer(4'b1000, 1000, 1000, 32'h0, o);
    ptr_model = 0;
    checks++; if (o.gnt !== 3 || o.rerr !== 1'b1 || o.rcyc !== T) begin errors++; $display("FAIL timeout_no_ack: got grant %0d err %0b cyc %0d expected 3 1 %0d", o.gnt, o.rerr, o.rcyc, T); end
    checks++; if (o.pdrop !== T) begin errors++; $display("FAIL timeout_no_ack_piso_req: got drop %0d expected %0d", o.pdrop, T); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    do_xfer(4'b0001, 2, T - 1, 32'h0BAD_C0DE, o);
    ptr_model = 1;
    checks++; if (o.rerr !== 1'b0 || o.rdata !== 32'h0BAD_C0DE || o.rcyc !== T) begin errors++; $display("FAIL expiry_race: got err %0b data %0h cyc %0d expected 0 0badc0de %0d", o.rerr, o.rdata, o.rcyc, T); end
    do_xfer(4'b0010, 5, 3, 32'h1111_2222, o);
    ptr_model = 2;
    checks++; if (o.rerr !== 1'b1 || o.rdata !== 32'h0 || o.rcyc !== T) begin errors++; $display("FAIL rdy_in_issue: got err %0b data %0h cyc %0d expected 1 0 %0d", o.rerr, o.rdata, o.rcyc, T); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [3:0]  m;
      logic [31:0] miso, edata;
      logic [4:0]  esize;
      logic        eerr;
      int          a, r, g, ercyc, epdrop;
      obs_t        o;
      m        = 4'($urandom_range(1, 15));
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req_size = 20'($urandom);
      a        = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(0, T - 2);
      r        = $urandom_range(0, T + 2);
      miso     = $urandom;
      g        = rr_pick({4'b0, m}, ptr_model, 4);
      ptr_model = (g + 1) % 4;
      model_xfer(a, r, ercyc, eerr, epdrop);
      edata = eerr ? 32'h0 : miso;
      esize = req_size[g*5 +: 5];
      do_xfer(m, a, r, miso, o);
      checks++; if (o.gnt !== g || o.lat !== 1) begin errors++; $display("FAIL rand[%0d]_grant: got %0d lat %0d expected %0d lat 1", it, o.gnt, o.lat, g); end
      checks++; if (o.pdata !== req_data[g*32 +: 32] || o.psize !== esize) begin errors++; $display("FAIL rand[%0d]_piso: got %0h/%0d expected %0h/%0d", it, o.pdata, o.psize, req_data[g*32 +: 32], esize); end
      checks++; if (o.rvld !== (4'd1 << g) || o.vwidth !== 1) begin errors++; $display("FAIL rand[%0d]_rsp_vld: got %b width %0d expected %b width 1", it, o.rvld, o.vwidth, 4'd1 << g); end
      checks++; if (o.rdata !== edata || o.rerr !== eerr) begin errors++; $display("FAIL rand[%0d]_rsp: got %0h err %0b expected %0h err %0b", it, o.rdata, o.rerr, edata, eerr); end
      checks++; if (o.rcyc !== ercyc || o.pdrop !== epdrop) begin errors++; $display("FAIL rand[%0d]_timing: got rsp %0d drop %0d expected %0d %0d", it, o.rcyc, o.pdrop, ercyc, epdrop); end
      checks++; if (piso_data !== o.pdata) begin errors++; $display("FAIL rand[%0d]_piso_hold: got %0h expected %0h", it, piso_data, o.pdata); end
    end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    obs_t o;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    req = 4'b0100;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ack == 4'd0 && n < 5);
    req = '0;
    piso_ack = 1'b1;
    @(negedge clk);
    piso_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_model = 0;
    checks++;
    if ({req_ack, rsp_vld, rsp_data, rsp_err, busy, piso_data, piso_size, piso_req} !== 80'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %0h expected 0", {req_ack, rsp_vld, rsp_data, rsp_err, busy, piso_data, piso_size, piso_req});
    end
    seen = 0;
    sipo_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sipo_rdy = 1'b0;
      if (rsp_vld != 4'd0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_rsp: got %0d responses expected 0", seen); end
    req_data = {$urandom, $urandom, $urandom, $urandom};
    do_xfer(4'b1111, 1, 3, 32'h7777_1234, o);
    ptr_model = 1;
    checks++; if (o.gnt !== 0 || o.rdata !== 32'h7777_1234) begin errors++; $display("FAIL reset_mid_regrant: got grant %0d data %0h expected 0 77771234", o.gnt, o.rdata); end
  endtask

  task automatic xfer3(input logic [2:0] m, output int g, output logic [2:0] vld);
    int n;
    g = -1; vld = '0; n = 0;
    while (busy3 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    req3  = m;
    data3 = {$urandom, $urandom, $urandom};
    n = 0;
    do begin @(negedge clk); n++; end while (ack3 == 3'd0 && n < 5);
    for (int i = 0; i < 3; i++) if (((ack3 >> i) & 3'd1) != 0) g = i;
    req3  = '0;
    pack3 = 1'b1;
    @(negedge clk);
    pack3  = 1'b0;
    srdy3  = 1'b1;
    sdata3 = $urandom;
    @(negedge clk);
    srdy3 = 1'b0;
    n = 0;
    while (vld3 == 3'd0 && n < 10) begin @(negedge clk); n++; end
    vld = vld3;
  endtask

  task automatic test_wrap3();
    logic [2:0] masks [5] = '{3'b010, 3'b011, 3'b110, 3'b100, 3'b011};
    int p3, g, eg;
    logic [2:0] vld;
    p3 = 0;
    for (int i = 0; i < 5; i++) begin
      eg = rr_pick({5'b0, masks[i]}, p3, 3);
      p3 = (eg + 1) % 3;
      xfer3(masks[i], g, vld);
      checks++;
      if (g !== eg || vld !== (3'd1 << eg)) begin errors++; $display("FAIL wrap3[%0d]: got grant %0d vld %b expected %0d", i, g, vld, eg); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_wrap3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
